uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command sequencer between the UART receiver and the SDRAM controller user port.
//  Collects received bytes into write/read command frames and issues one memory access per frame.
//  Returns a response byte stream to the UART transmitter.
//  Sits at top level: uart_rx -> uart_cmd_ctrl -> SDRAM ctrl; uart_cmd_ctrl -> uart_tx.
// PARAMETERS
//  ADDR_BYTES  3        address bytes per frame, MSB first; AW = 8*ADDR_BYTES (localparam)
//  DATA_BYTES  2        data bytes per word, MSB first; DW = 8*DATA_BYTES (localparam)
//  TIMEOUT     1000000  idle cycles allowed between frame bytes before the frame is aborted (>=2)
// PORTS
//  CLK        in   1   clock
//  RST        in   1   reset, asynchronous, active-high
//  RX_STB     in   1   received byte valid; held high until RX_ACK
//  RX_DAT     in   8   received byte
//  RX_ACK     out  1   byte consumed this cycle (combinational)
//  MEM_STB    out  1   memory request; held until MEM_ACK
//  MEM_WE     out  1   1 = write, 0 = read
//  MEM_ADR    out  AW  word address
//  MEM_DAT_W  out  DW  write data
//  MEM_ACK    in   1   request done; read data valid the same cycle
//  MEM_DAT_R  in   DW  read data
//  TX_STB     out  1   response byte valid; held until TX_ACK
//  TX_DAT     out  8   response byte
//  TX_ACK     in   1   response byte taken
//  ERR        out  1   one-cycle pulse on frame timeout
// BEHAVIOUR
//  Frame formats:
//   - 0x57 'W' + ADDR_BYTES + DATA_BYTES -> response 0x4B 'K'
//   - 0x52 'R' + ADDR_BYTES -> response DATA_BYTES of read data, MSB first
//   - any other opcode -> response 0x3F '?'; the opcode byte is consumed and no access is made
//  FSM states:
//   - IDLE: waiting for opcode
//   - ADDR: collecting address bytes
//   - DATA: collecting write-data bytes
//   - MEM: memory request outstanding
//   - RESP: sending response bytes
//  FSM transitions:
//   - IDLE -> ADDR on a valid opcode; IDLE -> RESP on an unknown opcode
//   - ADDR -> DATA (write) or MEM (read) after the last address byte
//   - DATA -> MEM after the last data byte
//   - MEM -> RESP on MEM_ACK
//   - RESP -> IDLE on TX_ACK of the final byte
//  RX_ACK = RX_STB & (state in IDLE/ADDR/DATA) & ~RST.
//   - Exactly one byte is consumed per RX_STB pulse.
//   - In MEM/RESP the byte is left pending (backpressure) and is not lost.
//  Address and data bytes are shifted in MSB first. A byte counter selects ADDR->DATA/MEM.
//  Latency:
//   - MEM_STB rises the cycle after the last frame byte is accepted.
//   - TX_STB rises the cycle after the accepting cycle of MEM_ACK (or of the bad opcode).
//  MEM handshake:
//   - MEM_WE, MEM_ADR and MEM_DAT_W are stable while MEM_STB is high.
//   - MEM_STB is low the cycle after MEM_ACK.
//   - MEM_ACK is ignored while MEM_STB is low.
//   - MEM_DAT_R is captured on MEM_ACK.
//  TX handshake:
//   - TX_DAT is stable while TX_STB is high.
//   - After TX_ACK, the next byte is presented the following cycle with TX_STB still high; the stream has no gap.
//   - TX_STB drops the cycle after the final TX_ACK.
//  Timeout:
//   - Active only in ADDR/DATA.
//   - The counter clears on every accepted byte and on entry.
//   - After TIMEOUT cycles with no byte: go to IDLE, pulse ERR for 1 cycle, discard the partial frame, issue no MEM_STB and no response.
//   - A byte accepted in the same cycle as the timeout wins, and no timeout occurs.
//   - Not active in IDLE, MEM or RESP; a stalled memory or TX is never aborted.
//  Reset values: state=IDLE; MEM_STB=0, MEM_WE=0, MEM_ADR=0, MEM_DAT_W=0, TX_STB=0, TX_DAT=0, ERR=0; RX_ACK=0 while RST is high.
//  RST mid-operation aborts immediately, including during an outstanding MEM_STB; the next frame starts clean.
// STRUCTURE
//  Shared include uart_cmd_defs.vh:
//   - opcode constants OP_WR=8'h57, OP_RD=8'h52
//   - response constants RSP_OK=8'h4B, RSP_BAD=8'h3F
//   - FSM state encodings
//  Sub-module uart_cmd_timeout: clearable down-counter, width $clog2(TIMEOUT), outputs a one-cycle expiry pulse.
// TESTING (ADDR_BYTES=3, DATA_BYTES=2)
//  1. Write:
//     Stimulus: RX 57 01 23 45 BE EF; MEM_ACK 3 cycles after MEM_STB.
//     Required: MEM_STB with WE=1, ADR=0x012345, DAT_W=0xBEEF held until ACK; then TX 0x4B.
//  2. Read:
//     Stimulus: RX 52 00 00 10; MEM_ACK with DAT_R=0xCAFE.
//     Required: WE=0, ADR=0x000010; TX 0xCA then 0xFE with no gap when TX_ACK is tied high.
//  3. Bad opcode:
//     Stimulus: RX 0x41, then frame 52 00 00 01.
//     Required: TX 0x3F with no MEM_STB; the following read frame completes normally.
//  4. Timeout:
//     Stimulus: RX 57 01, then silence for TIMEOUT cycles.
//     Required: ERR is a 1-cycle pulse, no MEM_STB, no TX; the next write frame uses a fresh address.
//  5. Backpressure:
//     Stimulus: hold TX_ACK low for 50 cycles while the next RX byte 0x52 arrives.
//     Required: RX_ACK=0 throughout; 0x52 is accepted as the next opcode after the response completes.
//  6. Reset:
//     Stimulus: assert RST during MEM_STB and during a partial frame.
//     Required: all outputs at reset values; a clean frame afterwards works.

Source files
------------

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command sequencer: opcodes, response
// bytes, FSM state encoding and a small width helper.
package uart_cmd_ctrl_pkg;

   localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
   localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
   localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
   localparam logic [7:0] RSP_BAD = 8'h3F;  // '?'

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_MEM  = 3'd3,
      ST_RESP = 3'd4
   } state_e;

   // Width of a counter that must hold 0 .. n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: clearable down-counter that reports a single-cycle
// expiry once TIMEOUT enabled cycles have passed since the last clear.
module uart_cmd_timeout #(
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [TW-1:0] cnt_q;

   // Reload on clear, otherwise count down toward zero while enabled
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= TW'(TIMEOUT - 1);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - TW'(1);
      end
   end

   // A clear in the same cycle suppresses expiry, so an arriving byte wins
   assign expire_o = en_i & ~clr_i & (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: assembles 'W'/'R' frames from received bytes,
// issues one memory access per frame and streams the response bytes back.
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_BYTES = 3,
   parameter int unsigned DATA_BYTES = 2,
   parameter int unsigned TIMEOUT    = 1000000
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    RX_STB,
   input  logic [7:0]              RX_DAT,
   output logic                    RX_ACK,
   output logic                    MEM_STB,
   output logic                    MEM_WE,
   output logic [8*ADDR_BYTES-1:0] MEM_ADR,
   output logic [8*DATA_BYTES-1:0] MEM_DAT_W,
   input  logic                    MEM_ACK,
   input  logic [8*DATA_BYTES-1:0] MEM_DAT_R,
   output logic                    TX_STB,
   output logic [7:0]              TX_DAT,
   input  logic                    TX_ACK,
   output logic                    ERR
);

   localparam int unsigned AW = 8 * ADDR_BYTES;
   localparam int unsigned DW = 8 * DATA_BYTES;
   localparam int unsigned CW = cnt_width((ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;       // bytes collected in current field
   logic [CW-1:0]   rsp_left_q;  // response bytes still to send after TX_DAT
   logic [AW-1:0]   adr_q;
   logic [DW-1:0]   wdat_q;
   logic [DW-1:0]   rdat_q;      // remaining read bytes, MSB aligned
   logic            we_q;
   logic            mem_stb_q;
   logic            tx_stb_q;
   logic [7:0]      tx_dat_q;
   logic            err_q;
   logic            rx_ack;
   logic            to_en;
   logic            to_expire;

   // A byte is taken only while collecting a frame; held off during MEM/RESP
   assign rx_ack = RX_STB & (state_q inside {ST_IDLE, ST_ADDR, ST_DATA}) & ~RST;
   assign to_en  = (state_q == ST_ADDR) || (state_q == ST_DATA);

   uart_cmd_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .CLK      (CLK),
      .RST      (RST),
      .clr_i    (rx_ack),
      .en_i     (to_en),
      .expire_o (to_expire)
   );

   // Frame sequencer with registered memory/TX handshake outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rsp_left_q <= '0;
         adr_q      <= '0;
         wdat_q     <= '0;
         rdat_q     <= '0;
         we_q       <= 1'b0;
         mem_stb_q  <= 1'b0;
         tx_stb_q   <= 1'b0;
         tx_dat_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         err_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (rx_ack) begin
                  cnt_q <= '0;
                  if ((RX_DAT == OP_WR) || (RX_DAT == OP_RD)) begin
                     we_q    <= (RX_DAT == OP_WR);
                     state_q <= ST_ADDR;
                  end else begin
                     tx_dat_q   <= RSP_BAD;
                     tx_stb_q   <= 1'b1;
                     rsp_left_q <= '0;
                     state_q    <= ST_RESP;
                  end
               end
            end

            ST_ADDR: begin
               if (rx_ack) begin
                  adr_q <= (adr_q << 8) | AW'(RX_DAT);
                  if (cnt_q == CW'(ADDR_BYTES - 1)) begin
                     cnt_q <= '0;
                     if (we_q) begin
                        state_q <= ST_DATA;
                     end else begin
                        mem_stb_q <= 1'b1;
                        state_q   <= ST_MEM;
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end else if (to_expire) begin
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end

            ST_DATA: begin
               if (rx_ack) begin
                  wdat_q <= (wdat_q << 8) | DW'(RX_DAT);
                  if (cnt_q == CW'(DATA_BYTES - 1)) begin
                     cnt_q     <= '0;
                     mem_stb_q <= 1'b1;
                     state_q   <= ST_MEM;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end else if (to_expire) begin
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end

            ST_MEM: begin
               if (mem_stb_q && MEM_ACK) begin
                  mem_stb_q <= 1'b0;
                  tx_stb_q  <= 1'b1;
                  state_q   <= ST_RESP;
                  if (we_q) begin
                     tx_dat_q   <= RSP_OK;
                     rsp_left_q <= '0;
                  end else begin
                     tx_dat_q   <= MEM_DAT_R[DW-1 -: 8];
                     rdat_q     <= MEM_DAT_R << 8;
                     rsp_left_q <= CW'(DATA_BYTES - 1);
                  end
               end
            end

            ST_RESP: begin
               if (TX_ACK) begin
                  if (rsp_left_q == '0) begin
                     tx_stb_q <= 1'b0;
                     state_q  <= ST_IDLE;
                  end else begin
                     tx_dat_q   <= rdat_q[DW-1 -: 8];
                     rdat_q     <= rdat_q << 8;
                     rsp_left_q <= rsp_left_q - CW'(1);
                  end
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign RX_ACK    = rx_ack;
   assign MEM_STB   = mem_stb_q;
   assign MEM_WE    = we_q & mem_stb_q;
   assign MEM_ADR   = adr_q;
   assign MEM_DAT_W = wdat_q;
   assign TX_STB    = tx_stb_q;
   assign TX_DAT    = tx_dat_q;
   assign ERR       = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl (3 address bytes, 2 data
// bytes, short timeout so the abort path is reachable quickly).
module tb_uart_cmd_ctrl;

   localparam int unsigned TO = 20;

   logic        CLK = 1'b0;
   logic        RST;
   logic        RX_STB;
   logic [7:0]  RX_DAT;
   logic        RX_ACK;
   logic        MEM_STB;
   logic        MEM_WE;
   logic [23:0] MEM_ADR;
   logic [15:0] MEM_DAT_W;
   logic        MEM_ACK;
   logic [15:0] MEM_DAT_R;
   logic        TX_STB;
   logic [7:0]  TX_DAT;
   logic        TX_ACK;
   logic        ERR;

   int checks = 0;
   int errors = 0;
   int mem_rises = 0;
   int tx_rises = 0;
   int err_cycles = 0;
   logic mem_prev = 1'b0;
   logic tx_prev = 1'b0;

   uart_cmd_ctrl #(
      .ADDR_BYTES (3),
      .DATA_BYTES (2),
      .TIMEOUT    (TO)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RX_STB    (RX_STB),
      .RX_DAT    (RX_DAT),
      .RX_ACK    (RX_ACK),
      .MEM_STB   (MEM_STB),
      .MEM_WE    (MEM_WE),
      .MEM_ADR   (MEM_ADR),
      .MEM_DAT_W (MEM_DAT_W),
      .MEM_ACK   (MEM_ACK),
      .MEM_DAT_R (MEM_DAT_R),
      .TX_STB    (TX_STB),
      .TX_DAT    (TX_DAT),
      .TX_ACK    (TX_ACK),
      .ERR       (ERR)
   );

   always #5 CLK = ~CLK;

   // Event counters used to prove that nothing happened during a window
   always @(posedge CLK) begin
      if (MEM_STB === 1'b1 && mem_prev !== 1'b1) mem_rises++;
      if (TX_STB === 1'b1 && tx_prev !== 1'b1) tx_rises++;
      if (ERR === 1'b1) err_cycles++;
      mem_prev <= MEM_STB;
      tx_prev  <= TX_STB;
   end

   // Present one byte and wait (bounded) for it to be taken; returns on the
   // falling edge after the accepting rising edge.
   task automatic send_byte(input logic [7:0] b);
      bit acked = 0;
      @(negedge CLK);
      RX_STB = 1'b1;
      RX_DAT = b;
      for (int i = 0; i < 200 && !acked; i++) begin
         #1;
         if (RX_ACK === 1'b1) acked = 1;
         @(negedge CLK);
      end
      RX_STB = 1'b0;
      if (!acked) begin
         checks++;
         errors++;
         $display("FAIL rx_accept: byte %h got no RX_ACK within 200 cycles", b);
      end
   endtask

   // Pulse MEM_ACK for one cycle with the given read data
   task automatic mem_ack_now(input logic [15:0] rd);
      MEM_ACK   = 1'b1;
      MEM_DAT_R = rd;
      @(negedge CLK);
      MEM_ACK   = 1'b0;
      MEM_DAT_R = 16'h0000;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      RX_STB = 1'b1;
      #1;
      checks++;
      if ({MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W, TX_STB, TX_DAT, ERR, RX_ACK} !== 53'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h exp 0",
                  {MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W, TX_STB, TX_DAT, ERR, RX_ACK});
      end
      @(negedge CLK);
      RX_STB = 1'b0;
      RST    = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_write;
      send_byte(8'h57); send_byte(8'h01); send_byte(8'h23);
      send_byte(8'h45); send_byte(8'hBE); send_byte(8'hEF);
      checks++;
      if (MEM_STB !== 1'b1) begin errors++; $display("FAIL wr_stb_latency: got %b exp 1", MEM_STB); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W} !== {1'b1, 1'b1, 24'h012345, 16'hBEEF}) begin
            errors++;
            $display("FAIL wr_req_hold[%0d]: got stb=%b we=%b adr=%h dat=%h exp 1 1 012345 beef",
                     i, MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W);
         end
         if (i < 2) @(negedge CLK);
      end
      @(negedge CLK);
      mem_ack_now(16'h0000);
      checks++;
      if ({MEM_STB, TX_STB, TX_DAT} !== {1'b0, 1'b1, 8'h4B}) begin
         errors++;
         $display("FAIL wr_resp: got mem_stb=%b tx_stb=%b tx=%h exp 0 1 4b", MEM_STB, TX_STB, TX_DAT);
      end
      TX_ACK = 1'b1;
      @(negedge CLK);
      TX_ACK = 1'b0;
      checks++;
      if (TX_STB !== 1'b0) begin errors++; $display("FAIL wr_tx_drop: got %b exp 0", TX_STB); end
      // Stray MEM_ACK while idle must be ignored
      MEM_ACK = 1'b1;
      @(negedge CLK);
      MEM_ACK = 1'b0;
      @(negedge CLK);
      checks++;
      if ({MEM_STB, TX_STB} !== 2'b00) begin
         errors++;
         $display("FAIL stray_ack: got mem_stb=%b tx_stb=%b exp 0 0", MEM_STB, TX_STB);
      end
   endtask

   task automatic test_read;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
      checks++;
      if ({MEM_STB, MEM_WE, MEM_ADR} !== {1'b1, 1'b0, 24'h000010}) begin
         errors++;
         $display("FAIL rd_req: got stb=%b we=%b adr=%h exp 1 0 000010", MEM_STB, MEM_WE, MEM_ADR);
      end
      mem_ack_now(16'hCAFE);
      checks++;
      if ({MEM_STB, TX_STB, TX_DAT} !== {1'b0, 1'b1, 8'hCA}) begin
         errors++;
         $display("FAIL rd_byte0: got mem_stb=%b tx_stb=%b tx=%h exp 0 1 ca", MEM_STB, TX_STB, TX_DAT);
      end
      TX_ACK = 1'b1;
      @(negedge CLK);
      checks++;
      if ({TX_STB, TX_DAT} !== {1'b1, 8'hFE}) begin
         errors++;
         $display("FAIL rd_byte1: got tx_stb=%b tx=%h exp 1 fe", TX_STB, TX_DAT);
      end
      @(negedge CLK);
      TX_ACK = 1'b0;
      checks++;
      if (TX_STB !== 1'b0) begin errors++; $display("FAIL rd_tx_drop: got %b exp 0", TX_STB); end
   endtask

   task automatic test_bad_opcode;
      int r0;
      r0 = mem_rises;
      send_byte(8'h41);
      checks++;
      if ({MEM_STB, TX_STB, TX_DAT} !== {1'b0, 1'b1, 8'h3F}) begin
         errors++;
         $display("FAIL bad_resp: got mem_stb=%b tx_stb=%b tx=%h exp 0 1 3f", MEM_STB, TX_STB, TX_DAT);
      end
      TX_ACK = 1'b1;
      @(negedge CLK);
      TX_ACK = 1'b0;
      checks++;
      if (TX_STB !== 1'b0 || mem_rises != r0) begin
         errors++;
         $display("FAIL bad_done: got tx_stb=%b mem_rises=%0d exp 0 %0d", TX_STB, mem_rises, r0);
      end
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      checks++;
      if ({MEM_STB, MEM_WE, MEM_ADR} !== {1'b1, 1'b0, 24'h000001}) begin
         errors++;
         $display("FAIL bad_next_req: got stb=%b we=%b adr=%h exp 1 0 000001", MEM_STB, MEM_WE, MEM_ADR);
      end
      mem_ack_now(16'h1234);
      TX_ACK = 1'b1;
      checks++;
      if ({TX_STB, TX_DAT} !== {1'b1, 8'h12}) begin
         errors++;
         $display("FAIL bad_next_b0: got tx_stb=%b tx=%h exp 1 12", TX_STB, TX_DAT);
      end
      @(negedge CLK);
      checks++;
      if ({TX_STB, TX_DAT} !== {1'b1, 8'h34}) begin
         errors++;
         $display("FAIL bad_next_b1: got tx_stb=%b tx=%h exp 1 34", TX_STB, TX_DAT);
      end
      @(negedge CLK);
      TX_ACK = 1'b0;
   endtask

   task automatic test_timeout;
      int r0, t0, e0;
      r0 = mem_rises; t0 = tx_rises; e0 = err_cycles;
      send_byte(8'h57);
      send_byte(8'h01);
      for (int i = 1; i <= int'(TO) + 1; i++) begin
         @(negedge CLK);
         checks++;
         if (ERR !== ((i == int'(TO)) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL to_err_cycle%0d: got %b exp %b", i, ERR, (i == int'(TO)));
         end
      end
      checks++;
      if (mem_rises != r0 || tx_rises != t0 || err_cycles != e0 + 1) begin
         errors++;
         $display("FAIL to_side_effects: got mem=%0d tx=%0d err=%0d exp %0d %0d %0d",
                  mem_rises, tx_rises, err_cycles, r0, t0, e0 + 1);
      end
      send_byte(8'h57); send_byte(8'hAA); send_byte(8'hBB);
      send_byte(8'hCC); send_byte(8'h11); send_byte(8'h22);
      checks++;
      if ({MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W} !== {1'b1, 1'b1, 24'hAABBCC, 16'h1122}) begin
         errors++;
         $display("FAIL to_next_req: got stb=%b we=%b adr=%h dat=%h exp 1 1 aabbcc 1122",
                  MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W);
      end
      mem_ack_now(16'h0000);
      TX_ACK = 1'b1;
      checks++;
      if ({TX_STB, TX_DAT} !== {1'b1, 8'h4B}) begin
         errors++;
         $display("FAIL to_next_resp: got tx_stb=%b tx=%h exp 1 4b", TX_STB, TX_DAT);
      end
      @(negedge CLK);
      TX_ACK = 1'b0;
   endtask

   task automatic test_timeout_boundary;
      int e0;
      e0 = err_cycles;
      send_byte(8'h57);
      // Next byte lands on exactly the cycle the timer would expire
      repeat (int'(TO) - 2) @(negedge CLK);
      send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h07); send_byte(8'h00); send_byte(8'h05);
      checks++;
      if ({MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W} !== {1'b1, 1'b1, 24'h000007, 16'h0005}
          || err_cycles != e0) begin
         errors++;
         $display("FAIL to_edge: got stb=%b we=%b adr=%h dat=%h err=%0d exp 1 1 000007 0005 %0d",
                  MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W, err_cycles, e0);
      end
      mem_ack_now(16'h0000);
      TX_ACK = 1'b1;
      @(negedge CLK);
      TX_ACK = 1'b0;
   endtask

   task automatic test_backpressure;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
      mem_ack_now(16'h5AA5);
      RX_STB = 1'b1;
      RX_DAT = 8'h52;
      for (int i = 0; i < 50; i++) begin
         #1;
         checks++;
         if ({RX_ACK, TX_STB, TX_DAT} !== {1'b0, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL bp_stall%0d: got rx_ack=%b tx_stb=%b tx=%h exp 0 1 5a", i, RX_ACK, TX_STB, TX_DAT);
         end
         @(negedge CLK);
      end
      TX_ACK = 1'b1;
      @(negedge CLK);
      #1;
      checks++;
      if ({RX_ACK, TX_STB, TX_DAT} !== {1'b0, 1'b1, 8'hA5}) begin
         errors++;
         $display("FAIL bp_byte1: got rx_ack=%b tx_stb=%b tx=%h exp 0 1 a5", RX_ACK, TX_STB, TX_DAT);
      end
      @(negedge CLK);
      TX_ACK = 1'b0;
      #1;
      checks++;
      if ({RX_ACK, TX_STB} !== 2'b10) begin
         errors++;
         $display("FAIL bp_release: got rx_ack=%b tx_stb=%b exp 1 0", RX_ACK, TX_STB);
      end
      @(negedge CLK);
      RX_STB = 1'b0;
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
      checks++;
      if ({MEM_STB, MEM_WE, MEM_ADR} !== {1'b1, 1'b0, 24'h000003}) begin
         errors++;
         $display("FAIL bp_next_req: got stb=%b we=%b adr=%h exp 1 0 000003", MEM_STB, MEM_WE, MEM_ADR);
      end
      mem_ack_now(16'h0102);
      TX_ACK = 1'b1;
      @(negedge CLK);
      checks++;
      if ({TX_STB, TX_DAT} !== {1'b1, 8'h02}) begin
         errors++;
         $display("FAIL bp_next_b1: got tx_stb=%b tx=%h exp 1 02", TX_STB, TX_DAT);
      end
      @(negedge CLK);
      TX_ACK = 1'b0;
   endtask

   task automatic test_reset_midop;
      send_byte(8'h52); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
      checks++;
      if (MEM_STB !== 1'b1) begin errors++; $display("FAIL rst_pre_stb: got %b exp 1", MEM_STB); end
      RST    = 1'b1;
      RX_STB = 1'b1;
      RX_DAT = 8'h57;
      #1;
      checks++;
      if ({MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W, TX_STB, TX_DAT, ERR, RX_ACK} !== 53'd0) begin
         errors++;
         $display("FAIL rst_mem: got %h exp 0",
                  {MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W, TX_STB, TX_DAT, ERR, RX_ACK});
      end
      @(negedge CLK);
      RST    = 1'b0;
      RX_STB = 1'b0;
      @(negedge CLK);
      checks++;
      if ({MEM_STB, TX_STB} !== 2'b00) begin
         errors++;
         $display("FAIL rst_after_mem: got mem_stb=%b tx_stb=%b exp 0 0", MEM_STB, TX_STB);
      end
      send_byte(8'h57); send_byte(8'h01);
      RST = 1'b1;
      #1;
      checks++;
      if ({MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W, TX_STB, TX_DAT, ERR, RX_ACK} !== 53'd0) begin
         errors++;
         $display("FAIL rst_partial: got %h exp 0",
                  {MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W, TX_STB, TX_DAT, ERR, RX_ACK});
      end
      @(negedge CLK);
      RST = 1'b0;
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h09); send_byte(8'hAB); send_byte(8'hCD);
      checks++;
      if ({MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W} !== {1'b1, 1'b1, 24'h000009, 16'hABCD}) begin
         errors++;
         $display("FAIL rst_clean_req: got stb=%b we=%b adr=%h dat=%h exp 1 1 000009 abcd",
                  MEM_STB, MEM_WE, MEM_ADR, MEM_DAT_W);
      end
      mem_ack_now(16'h0000);
      checks++;
      if ({TX_STB, TX_DAT} !== {1'b1, 8'h4B}) begin
         errors++;
         $display("FAIL rst_clean_resp: got tx_stb=%b tx=%h exp 1 4b", TX_STB, TX_DAT);
      end
      TX_ACK = 1'b1;
      @(negedge CLK);
      TX_ACK = 1'b0;
   endtask

   initial begin
      RST       = 1'b1;
      RX_STB    = 1'b0;
      RX_DAT    = 8'h00;
      MEM_ACK   = 1'b0;
      MEM_DAT_R = 16'h0000;
      TX_ACK    = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_bad_opcode();
      test_timeout();
      test_timeout_boundary();
      test_backpressure();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop if the sequence above ever stalls
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
